johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Receive-side companion to the team's Johnson counter. Samples a Johnson-coded bus driven by a remote counter, checks that each code is legal, decodes it to a binary phase index, and checks that consecutive codes follow the counter's successor order. A lock state machine reports when the incoming sequence can be trusted, and a sticky error counter records loss-of-sequence events. It sits at the boundary where a Johnson phase bus enters a block that needs a numeric phase.

## Interface
- `WIDTH_REG`, default 4: Johnson code width; sequence length is 2·WIDTH_REG. Minimum 2.
- `LOCK_CNT`, default 3: consecutive in-order legal samples needed to lock. Minimum 2.
- `ERR_W`, default 8: error counter width.
- `clk` input 1: single clock, rising edge.
- `n_rst` input 1: reset is synchronous and active-low.
- `in_code` input WIDTH_REG: sampled Johnson code.
- `in_valid` input 1: `in_code` is meaningful this cycle.
- `out_index` output IDXW=$clog2(2·WIDTH_REG): decoded phase index of the last legal sample.
- `out_valid` output 1: a sample was processed last cycle.
- `out_legal` output 1: that sample was a legal Johnson code.
- `locked` output 1: sequence lock established.
- `seq_err` output 1: one-cycle pulse on loss of lock.
- `err_cnt` output ERR_W: saturating count of loss-of-lock events.

## Operation
- **Sequence.** The counter sequence is 0…0 → 10…0 → 110…0 → … → 1…1 → 01…1 → … → 0…01 → 0…0. Each step shifts right and inserts ~bit0 at the MSB.
- **Legality.** A code is legal iff at most one adjacent-bit pair in[i] ≠ in[i+1] differs, for i = 0..W-2.
- **Index.**
  - If the code is all zeros, or MSB = 1: index = popcount(code).
  - Otherwise: index = 2W − popcount(code).
  - Range is 0..2W−1. Example for W=4: 0000→0, 1110→3, 0111→5, 0001→7.
- **Successor.** succ = (prev_index + 1) mod 2W. Index 2W−1 wraps to 0.
- **Reference update.** `prev_index` updates on every valid legal sample. `run_cnt` ranges 0..LOCK_CNT.
- **States.**
  - **UNLOCKED**
    - Valid legal sample → ACQUIRE, run_cnt = 1.
    - Valid illegal sample → stay.
  - **ACQUIRE**
    - Legal and equal to succ → run_cnt + 1. Reaching LOCK_CNT → LOCKED.
    - Legal but not succ → stay, run_cnt = 1 (new reference).
    - Illegal → UNLOCKED, run_cnt = 0.
  - **LOCKED**
    - Legal successor → stay.
    - Illegal sample or wrong index → UNLOCKED, run_cnt = 0, `seq_err` pulse, `err_cnt` + 1.
    - A legal out-of-order sample in this case still updates `prev_index` but does not start ACQUIRE. The next legal sample does that.
- **Error counter.** `err_cnt` saturates at all-ones.
- **Idle cycles.** `in_valid` = 0 is a hold: no state, counter, or reference change.
- **`locked`** = (state == LOCKED).

## Timing
- **Reset values.** `n_rst` low at a rising edge resets, and it overrides any sample that cycle. After reset:
  - `out_index` = 0, `out_valid` = 0, `out_legal` = 0
  - `locked` = 0, `seq_err` = 0, `err_cnt` = 0
  - state UNLOCKED, run_cnt = 0, prev_index = 0
- **Latency.** One cycle. A sample at edge N produces `out_*`, `locked` and `seq_err` after edge N+1.
- **`out_valid`** equals `in_valid` delayed by one cycle.
- **`out_index` on an illegal sample:** holds its previous value, and `out_legal` = 0.
- **`locked` rise:** goes high in the same cycle `out_valid` reports the LOCK_CNT-th in-order sample.
- **`locked` fall:** goes low in the same cycle `seq_err` pulses.
- **Back-to-back `in_valid` is supported:** one sample per cycle, no backpressure.
- **Reset mid-operation** returns to the reset values; `err_cnt` is not preserved.

## Configuration
- `JOHNSON_DEC_ERR_CNT_EN` defined: `err_cnt` register implemented as specified.
- Not defined:
  - `err_cnt` is tied to 0 and no counter flops exist.
  - `seq_err`, lock, and decode behaviour are unchanged.

## Structure
- Package `johnson_pkg`:
  - state enum `jdec_state_t` {UNLOCKED, ACQUIRE, LOCKED}
  - IDXW helper function `johnson_idx_w(width)`
  - pure functions `johnson_is_legal` and `johnson_to_index`, parameterised via width argument
- One combinational sub-module, `johnson_code_check`, produces the legal flag and index from `in_code`. The top holds the FSM, registers and counter.

## Test plan
All scenarios use W=4, LOCK_CNT=3.
- **Reset.** Hold `n_rst` = 0 for 2 cycles → all outputs 0, `locked` = 0.
- **Full sequence, lock and wrap.** Feed 0000,1000,1100,…,0001,0000 with `in_valid` = 1 every cycle → `out_index` 0..7 then 0; `locked` rises with index 2 reported; no `seq_err` across the 7→0 wrap.
- **Illegal code while locked.** Locked, then inject 1010 → `out_legal` = 0, `out_index` holds, `seq_err` pulses 1 cycle, `locked` = 0, `err_cnt` = 1.
- **Skipped code, then relock.** Locked at index 3, next sample 0011 (index 6) → `seq_err`, UNLOCKED. Continue 0001,0000,1000 → relock after 3 in-order samples.
- **`in_valid` gaps.** Locked, deassert `in_valid` for 5 cycles between 1100 and 1110 → `locked` stays 1, no `seq_err`, `out_valid` 0 during the gap.
- **Saturation and macro off.** With `ERR_W` = 2, force 4 loss events → `err_cnt` = 3. Without `JOHNSON_DEC_ERR_CNT_EN` → `err_cnt` stays 0 while `seq_err` still pulses 4 times.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and pure helpers for the Johnson-code receive path.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } jdec_state_t;

  // Helpers take a fixed-width container; only the low `width` bits matter.
  localparam int unsigned JOHNSON_MAX_W = 32;

  function automatic int unsigned johnson_idx_w(input int unsigned width);
    return $clog2(2 * width);
  endfunction

  function automatic logic johnson_is_legal(input logic [JOHNSON_MAX_W-1:0] code,
                                            input int unsigned width);
    int unsigned edges;
    edges = 0;
    for (int unsigned i = 0; i < JOHNSON_MAX_W - 1; i++) begin
      if ((i + 1 < width) && (code[i] != code[i+1])) edges++;
    end
    return (edges <= 1);
  endfunction

  function automatic int unsigned johnson_to_index(input logic [JOHNSON_MAX_W-1:0] code,
                                                   input int unsigned width);
    int unsigned pop;
    pop = 0;
    for (int unsigned i = 0; i < JOHNSON_MAX_W; i++) begin
      if ((i < width) && code[i]) pop++;
    end
    if ((pop == 0) || code[width-1]) return pop;
    return (2 * width) - pop;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and phase-index decode of one Johnson code.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH_REG = 4,
  parameter int unsigned IDXW      = johnson_idx_w(WIDTH_REG)
) (
  input  logic [WIDTH_REG-1:0] in_code,
  output logic                 legal,
  output logic [IDXW-1:0]      index
);

  logic [JOHNSON_MAX_W-1:0] code_ext;

  always_comb begin
    code_ext                = '0;
    code_ext[WIDTH_REG-1:0] = in_code;
    legal                   = johnson_is_legal(code_ext, WIDTH_REG);
    index                   = IDXW'(johnson_to_index(code_ext, WIDTH_REG));
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson bus receiver: decode, successor check, lock FSM and loss-of-lock counter.
// Define JOHNSON_DEC_ERR_CNT_EN to implement the err_cnt register; otherwise err_cnt reads 0.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int unsigned WIDTH_REG = 4,
  parameter  int unsigned LOCK_CNT  = 3,
  parameter  int unsigned ERR_W     = 8,
  localparam int unsigned IDXW      = johnson_idx_w(WIDTH_REG)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [WIDTH_REG-1:0] in_code,
  input  logic                 in_valid,
  output logic [IDXW-1:0]      out_index,
  output logic                 out_valid,
  output logic                 out_legal,
  output logic                 locked,
  output logic                 seq_err,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam int unsigned     RUNW     = $clog2(LOCK_CNT + 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(2 * WIDTH_REG - 1);

  logic            code_legal;
  logic [IDXW-1:0] code_index;
  logic [IDXW-1:0] succ;
  logic            in_order;

  jdec_state_t     state_q,      state_d;
  logic [RUNW-1:0] run_cnt_q,    run_cnt_d;
  logic [IDXW-1:0] prev_index_q, prev_index_d;
  logic [IDXW-1:0] out_index_q,  out_index_d;
  logic            out_valid_q,  out_valid_d;
  logic            out_legal_q,  out_legal_d;
  logic            seq_err_q,    seq_err_d;

  johnson_code_check #(
    .WIDTH_REG (WIDTH_REG),
    .IDXW      (IDXW)
  ) u_check (
    .in_code (in_code),
    .legal   (code_legal),
    .index   (code_index)
  );

  always_comb begin
    succ     = (prev_index_q == IDX_LAST) ? '0 : prev_index_q + 1'b1;
    in_order = code_legal && (code_index == succ);
  end

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    prev_index_d = prev_index_q;
    out_index_d  = out_index_q;
    out_valid_d  = in_valid;
    out_legal_d  = in_valid & code_legal;
    seq_err_d    = 1'b0;
    if (in_valid) begin
      // Reference follows every legal sample, including the one that breaks lock.
      if (code_legal) begin
        prev_index_d = code_index;
        out_index_d  = code_index;
      end
      unique case (state_q)
        UNLOCKED: begin
          if (code_legal) begin
            state_d   = ACQUIRE;
            run_cnt_d = RUNW'(1);
          end
        end
        ACQUIRE: begin
          if (!code_legal) begin
            state_d   = UNLOCKED;
            run_cnt_d = '0;
          end else if (in_order) begin
            if (run_cnt_q == RUNW'(LOCK_CNT - 1)) begin
              state_d   = LOCKED;
              run_cnt_d = RUNW'(LOCK_CNT);
            end else begin
              run_cnt_d = run_cnt_q + 1'b1;
            end
          end else begin
            run_cnt_d = RUNW'(1);
          end
        end
        LOCKED: begin
          if (!in_order) begin
            state_d   = UNLOCKED;
            run_cnt_d = '0;
            seq_err_d = 1'b1;
          end
        end
        default: begin
          state_d   = UNLOCKED;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= UNLOCKED;
      run_cnt_q    <= '0;
      prev_index_q <= '0;
      out_index_q  <= '0;
      out_valid_q  <= 1'b0;
      out_legal_q  <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      prev_index_q <= prev_index_d;
      out_index_q  <= out_index_d;
      out_valid_q  <= out_valid_d;
      out_legal_q  <= out_legal_d;
      seq_err_q    <= seq_err_d;
    end
  end

`ifdef JOHNSON_DEC_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (seq_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign out_index = out_index_q;
  assign out_valid = out_valid_q;
  assign out_legal = out_legal_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (W=4, LOCK_CNT=3, ERR_W=2).
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] in_code = '0;
  logic       in_valid = 1'b0;
  logic [2:0] out_index;
  logic       out_valid, out_legal, locked, seq_err;
  logic [1:0] err_cnt;

  always #5 clk = ~clk;

  johnson_decoder #(
    .WIDTH_REG (4),
    .LOCK_CNT  (3),
    .ERR_W     (2)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_legal (out_legal),
    .locked    (locked),
    .seq_err   (seq_err),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic       valid;
    logic       legal;
    logic [2:0] index;
    logic       lock;
    logic       serr;
    logic [1:0] err;
  } exp_t;

  exp_t exp_q[$];

  // Reference sequence: position in the table is the phase index.
  logic [3:0] seq_tab [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};

  int n_checks = 0;
  int n_pass   = 0;

  int m_state = 0;  // 0 unlocked, 1 acquire, 2 locked
  int m_run   = 0;
  int m_prev  = 0;
  int m_idx   = 0;
  int m_err   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_step(input logic rst_n_v, input logic v, input logic [3:0] code);
    exp_t e;
    bit   legal;
    int   idx;
    int   succ;
    bit   serr;
    legal = 1'b0;
    idx   = 0;
    serr  = 1'b0;
    if (!rst_n_v) begin
      m_state = 0; m_run = 0; m_prev = 0; m_idx = 0; m_err = 0;
      e.valid = 1'b0;
      e.legal = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (seq_tab[k] == code) begin
          legal = 1'b1;
          idx   = k;
        end
      end
      e.valid = v;
      e.legal = v & legal;
      if (v) begin
        succ = (m_prev + 1) % 8;
        case (m_state)
          0: if (legal) begin m_state = 1; m_run = 1; end
          1: begin
            if (!legal) begin m_state = 0; m_run = 0; end
            else if (idx == succ) begin
              m_run++;
              if (m_run == 3) m_state = 2;
            end else m_run = 1;
          end
          default: begin
            if (!(legal && idx == succ)) begin
              m_state = 0; m_run = 0; serr = 1'b1;
`ifdef JOHNSON_DEC_ERR_CNT_EN
              if (m_err < 3) m_err++;
`endif
            end
          end
        endcase
        if (legal) begin
          m_prev = idx;
          m_idx  = idx;
        end
      end
    end
    e.index = 3'(m_idx);
    e.lock  = (m_state == 2);
    e.serr  = serr;
    e.err   = 2'(m_err);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst_n_v, input logic v, input logic [3:0] code);
    exp_t e;
    @(negedge clk);
    n_rst    = rst_n_v;
    in_valid = v;
    in_code  = code;
    model_step(rst_n_v, v, code);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("out_valid", 32'(out_valid), 32'(e.valid));
    if (e.valid) check_eq("out_legal", 32'(out_legal), 32'(e.legal));
    check_eq("out_index", 32'(out_index), 32'(e.index));
    check_eq("locked",    32'(locked),    32'(e.lock));
    check_eq("seq_err",   32'(seq_err),   32'(e.serr));
    check_eq("err_cnt",   32'(err_cnt),   32'(e.err));
  endtask

  task automatic feed(input int idx);
    logic [3:0] c;
    c = seq_tab[idx % 8];
    step(1'b1, 1'b1, c);
  endtask

  initial begin
    int phase;
    logic [3:0] rc;

    // Reset held two cycles, with a sample present that must be ignored
    step(1'b0, 1'b1, 4'b1000);
    step(1'b0, 1'b1, 4'b1000);

    // Full sequence, lock on index 2, wrap 7 -> 0
    for (int i = 0; i <= 8; i++) feed(i);

    // Illegal code while locked
    feed(1);
    step(1'b1, 1'b1, 4'b1010);

    // Relock at 3, skip to 6, then relock on 7,0,1
    feed(1); feed(2); feed(3);
    step(1'b1, 1'b1, 4'b0011);
    feed(7); feed(0); feed(1);

    // Idle gap while locked
    feed(2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b1010);
    feed(3);

    // Further loss events to reach saturation
    step(1'b1, 1'b1, 4'b0110);
    feed(4); feed(5); feed(6);
    step(1'b1, 1'b1, 4'b1101);
    feed(0); feed(1); feed(2);
    step(1'b1, 1'b1, 4'b1001);

    // Illegal in UNLOCKED, out-of-order re-reference and illegal in ACQUIRE
    step(1'b1, 1'b1, 4'b0101);
    feed(0); feed(4); feed(5);
    step(1'b1, 1'b1, 4'b0100);
    feed(5); feed(6); feed(7); feed(0);

    // Mid-operation reset clears everything including err_cnt
    step(1'b0, 1'b0, 4'b0000);
    feed(3); feed(4); feed(5);

    // Random mix: mostly in-order, some gaps, skips and arbitrary codes
    phase = 6;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: step(1'b1, 1'b0, 4'($urandom));
        1: begin
          rc = 4'($urandom);
          step(1'b1, 1'b1, rc);
        end
        2: begin
          phase = (phase + 2) % 8;
          feed(phase);
        end
        default: begin
          phase = (phase + 1) % 8;
          feed(phase);
        end
      endcase
      if (i == 150) step(1'b0, 1'b1, 4'b0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
